// File: rtl/text_pkg.sv
// Shared types and constants for the text overlay scheduler.
package text_pkg;

    localparam int         TEXT_SPR_W       = 42;
    localparam int         TEXT_SPR_H       = 38;
    localparam logic [5:0] TEXT_TRANSPARENT = 6'h00;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] sel;
        logic       en;
        logic       blink;
    } text_slot_t;

endpackage

// File: rtl/text_slot_hit.sv
// Window test for one text slot plus the sprite-local coordinates of the current pixel.
module text_slot_hit
    import text_pkg::*;
#(
    parameter int SPR_W = TEXT_SPR_W,
    parameter int SPR_H = TEXT_SPR_H
) (
    input  text_slot_t i_slot,
    input  logic       i_hide,
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    output logic       o_hit,
    output logic [5:0] o_loc_x,
    output logic [5:0] o_loc_y
);

    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_in_x;
    logic        w_in_y;

    // One extra bit so an origin near the right/bottom edge cannot wrap back to 0.
    assign w_x_end = {1'b0, i_slot.x} + 11'(SPR_W);
    assign w_y_end = {1'b0, i_slot.y} + 11'(SPR_H);

    assign w_in_x = (i_draw_x >= i_slot.x) && ({1'b0, i_draw_x} < w_x_end);
    assign w_in_y = (i_draw_y >= i_slot.y) && ({1'b0, i_draw_y} < w_y_end);

    assign o_hit   = i_slot.en && !i_hide && w_in_x && w_in_y;
    assign o_loc_x = 6'(i_draw_x - i_slot.x);
    assign o_loc_y = 6'(i_draw_y - i_slot.y);

endmodule

// File: rtl/text_overlay_sched.sv
// Shares one text-sprite ROM port among NUM_SLOTS overlay slots; 2-stage pixel pipeline.
// Optional blinking is built only when TEXT_BLINK_EN is defined.
module text_overlay_sched
    import text_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SPR_W        = TEXT_SPR_W,
    parameter int SPR_H        = TEXT_SPR_H,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       cfg_we,
    input  logic [1:0] cfg_slot,
    input  logic [9:0] cfg_x,
    input  logic [9:0] cfg_y,
    input  logic [1:0] cfg_sel,
    input  logic       cfg_en,
    input  logic       cfg_blink,
    output logic [5:0] RomX,
    output logic [5:0] RomY,
    output logic [1:0] RomSel,
    input  logic [5:0] RomData,
    output logic [5:0] TextPixel,
    output logic       TextValid
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [2:0]  r_fsync;
    logic        w_frame_tick;
    text_slot_t  r_shadow [NUM_SLOTS];
    text_slot_t  r_active [NUM_SLOTS];
    logic        w_phase;

    logic [NUM_SLOTS-1:0]      w_hit;
    logic [NUM_SLOTS-1:0][5:0] w_loc_x;
    logic [NUM_SLOTS-1:0][5:0] w_loc_y;
    logic                      w_any;
    logic [SW-1:0]             w_win;

    logic [5:0] r_rom_x;
    logic [5:0] r_rom_y;
    logic [1:0] r_rom_sel;
    logic       r_hit_q;
    logic [5:0] r_text_pixel;
    logic       r_text_valid;

    // frame_clk is asynchronous: two sync flops, third flop for edge detect.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_fsync <= '0;
        else       r_fsync <= {r_fsync[1:0], frame_clk};
    end

    assign w_frame_tick = r_fsync[1] & ~r_fsync[2];

    // Commit reads the shadow before this cycle's write lands.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_frame_tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) r_active[i] <= r_shadow[i];
            end
            if (cfg_we) begin
                r_shadow[cfg_slot] <= '{x: cfg_x, y: cfg_y, sel: cfg_sel,
                                        en: cfg_en, blink: cfg_blink};
            end
        end
    end

`ifdef TEXT_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_phase;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + CNT_W'(1);
            end
        end
    end

    assign w_phase = r_phase;
`else
    assign w_phase = 1'b0;
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        text_slot_hit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H)
        ) u_hit (
            .i_slot   (r_active[g]),
            .i_hide   (r_active[g].blink & w_phase),
            .i_draw_x (DrawX),
            .i_draw_y (DrawY),
            .o_hit    (w_hit[g]),
            .o_loc_x  (w_loc_x[g]),
            .o_loc_y  (w_loc_y[g])
        );
    end

    // Scan high to low so the lowest hitting index overrides.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = SW'(i);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_x   <= '0;
            r_rom_y   <= '0;
            r_rom_sel <= '0;
            r_hit_q   <= 1'b0;
        end else begin
            r_hit_q <= w_any;
            if (w_any) begin
                r_rom_x   <= w_loc_x[w_win];
                r_rom_y   <= w_loc_y[w_win];
                r_rom_sel <= r_active[w_win].sel;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_text_pixel <= '0;
            r_text_valid <= 1'b0;
        end else begin
            r_text_pixel <= r_hit_q ? RomData : '0;
            r_text_valid <= r_hit_q && (RomData != TEXT_TRANSPARENT);
        end
    end

    assign RomX      = r_rom_x;
    assign RomY      = r_rom_y;
    assign RomSel    = r_rom_sel;
    assign TextPixel = r_text_pixel;
    assign TextValid = r_text_valid;

endmodule

// File: tb/tb_text_overlay_sched.sv
// Directed bench for text_overlay_sched; ROM model returns {1, X+Y+Sel} (5-bit sum) unless forced to 0.
module tb_text_overlay_sched;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_slot = '0;
    logic [9:0] cfg_x = '0, cfg_y = '0;
    logic [1:0] cfg_sel = '0;
    logic       cfg_en = 1'b0, cfg_blink = 1'b0;
    logic [5:0] RomX, RomY, RomData, TextPixel;
    logic [1:0] RomSel;
    logic       TextValid;
    logic       rom_zero = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] o_rx, o_ry, o_pix;
    logic [1:0] o_rs;
    logic       o_vld;

    text_overlay_sched dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_sel(cfg_sel), .cfg_en(cfg_en), .cfg_blink(cfg_blink),
        .RomX(RomX), .RomY(RomY), .RomSel(RomSel), .RomData(RomData),
        .TextPixel(TextPixel), .TextValid(TextValid)
    );

    always #5 Clk = ~Clk;

    assign RomData = rom_zero ? 6'h00 : {1'b1, RomX[4:0] + RomY[4:0] + {3'b000, RomSel}};

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic cfg(input int s, input int x, input int y, input int sel, input bit en, input bit bl);
        cfg_we = 1'b1; cfg_slot = 2'(s); cfg_x = 10'(x); cfg_y = 10'(y);
        cfg_sel = 2'(sel); cfg_en = en; cfg_blink = bl;
        @(negedge Clk);
        cfg_we = 1'b0;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        @(negedge Clk);
        o_rx = RomX; o_ry = RomY; o_rs = RomSel;
        @(negedge Clk);
        o_pix = TextPixel; o_vld = TextValid;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        DrawX = 10'd100; DrawY = 10'd50;
        repeat (3) @(negedge Clk);
        n_tests++; if ({RomX, RomY, RomSel} !== 14'h0) begin n_fail++; $display("FAIL reset_rom: got %0h expected 0", {RomX, RomY, RomSel}); end
        n_tests++; if ({TextPixel, TextValid} !== 7'h0) begin n_fail++; $display("FAIL reset_text: got %0h expected 0", {TextPixel, TextValid}); end
        Reset = 1'b0;
        @(negedge Clk);
        pix(100, 50);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_noslot_vld: got %0d expected 0", o_vld); end
    endtask

    task automatic test_basic();
        cfg(0, 100, 50, 1, 1'b1, 1'b0);
        pix(100, 50);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL shadow_not_active: got %0d expected 0", o_vld); end
        tick();
        pix(100, 50);
        n_tests++; if ({o_rx, o_ry, o_rs} !== {6'd0, 6'd0, 2'd1}) begin n_fail++; $display("FAIL origin_rom: got %0h expected %0h", {o_rx, o_ry, o_rs}, {6'd0, 6'd0, 2'd1}); end
        n_tests++; if ({o_vld, o_pix} !== {1'b1, 6'h21}) begin n_fail++; $display("FAIL origin_pix: got %0h expected %0h", {o_vld, o_pix}, {1'b1, 6'h21}); end
        pix(141, 50);
        n_tests++; if (o_rx !== 6'd41) begin n_fail++; $display("FAIL right_edge_romx: got %0d expected 41", o_rx); end
        n_tests++; if ({o_vld, o_pix} !== {1'b1, 6'h2A}) begin n_fail++; $display("FAIL right_edge_pix: got %0h expected %0h", {o_vld, o_pix}, {1'b1, 6'h2A}); end
        pix(142, 50);
        n_tests++; if ({o_vld, o_pix} !== 7'h0) begin n_fail++; $display("FAIL past_right: got %0h expected 0", {o_vld, o_pix}); end
        n_tests++; if (o_rx !== 6'd41) begin n_fail++; $display("FAIL romx_hold: got %0d expected 41", o_rx); end
        pix(100, 88);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL past_bottom: got %0d expected 0", o_vld); end
        pix(100, 87);
        n_tests++; if ({o_ry, o_vld, o_pix} !== {6'd37, 1'b1, 6'h26}) begin n_fail++; $display("FAIL bottom_row: got %0h expected %0h", {o_ry, o_vld, o_pix}, {6'd37, 1'b1, 6'h26}); end
        pix(99, 50);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL left_of_origin: got %0d expected 0", o_vld); end
    endtask

    task automatic test_back_to_back();
        int         xs [5]  = '{140, 141, 142, 143, 100};
        logic [6:0] exp [5] = '{{1'b1, 6'h29}, {1'b1, 6'h2A}, 7'h0, 7'h0, {1'b1, 6'h21}};
        DrawY = 10'd50;
        for (int k = 0; k < 7; k++) begin
            if (k >= 2) begin
                n_tests++;
                if ({TextValid, TextPixel} !== exp[k-2]) begin
                    n_fail++; $display("FAIL stream_%0d: got %0h expected %0h", k - 2, {TextValid, TextPixel}, exp[k-2]);
                end
            end
            if (k < 5) DrawX = 10'(xs[k]);
            @(negedge Clk);
        end
    endtask

    task automatic test_priority();
        cfg(1, 110, 55, 2, 1'b1, 1'b0);
        tick();
        pix(120, 60);
        n_tests++; if ({o_rs, o_rx, o_ry} !== {2'd1, 6'd20, 6'd10}) begin n_fail++; $display("FAIL overlap_slot0: got %0h expected %0h", {o_rs, o_rx, o_ry}, {2'd1, 6'd20, 6'd10}); end
        n_tests++; if ({o_vld, o_pix} !== {1'b1, 6'h3F}) begin n_fail++; $display("FAIL overlap_slot0_pix: got %0h expected %0h", {o_vld, o_pix}, {1'b1, 6'h3F}); end
        cfg(0, 100, 50, 1, 1'b0, 1'b0);
        tick();
        pix(120, 60);
        n_tests++; if ({o_rs, o_rx, o_ry} !== {2'd2, 6'd10, 6'd5}) begin n_fail++; $display("FAIL overlap_slot1: got %0h expected %0h", {o_rs, o_rx, o_ry}, {2'd2, 6'd10, 6'd5}); end
        n_tests++; if ({o_vld, o_pix} !== {1'b1, 6'h31}) begin n_fail++; $display("FAIL overlap_slot1_pix: got %0h expected %0h", {o_vld, o_pix}, {1'b1, 6'h31}); end
    endtask

    task automatic test_commit_race();
        cfg(1, 110, 55, 2, 1'b0, 1'b0);
        cfg(0, 100, 50, 1, 1'b1, 1'b0);
        tick();
        // Write lands on the same edge the tick commits.
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        cfg(0, 300, 50, 1, 1'b1, 1'b0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        pix(100, 50);
        n_tests++; if ({o_vld, o_pix} !== {1'b1, 6'h21}) begin n_fail++; $display("FAIL race_old_kept: got %0h expected %0h", {o_vld, o_pix}, {1'b1, 6'h21}); end
        pix(300, 50);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL race_new_early: got %0d expected 0", o_vld); end
        tick();
        pix(300, 50);
        n_tests++; if ({o_rx, o_vld, o_pix} !== {6'd0, 1'b1, 6'h21}) begin n_fail++; $display("FAIL race_new_active: got %0h expected %0h", {o_rx, o_vld, o_pix}, {6'd0, 1'b1, 6'h21}); end
        pix(100, 50);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL race_old_gone: got %0d expected 0", o_vld); end
    endtask

    task automatic test_transparent();
        rom_zero = 1'b1;
        pix(310, 60);
        n_tests++; if ({o_vld, o_pix} !== 7'h0) begin n_fail++; $display("FAIL transparent: got %0h expected 0", {o_vld, o_pix}); end
        n_tests++; if ({o_rx, o_ry} !== {6'd10, 6'd10}) begin n_fail++; $display("FAIL transparent_rom: got %0h expected %0h", {o_rx, o_ry}, {6'd10, 6'd10}); end
        rom_zero = 1'b0;
    endtask

    task automatic test_nowrap();
        cfg(0, 1000, 0, 3, 1'b1, 1'b0);
        tick();
        pix(5, 0);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL nowrap_x5: got %0d expected 0", o_vld); end
        pix(1010, 0);
        n_tests++; if ({o_rx, o_rs, o_vld, o_pix} !== {6'd10, 2'd3, 1'b1, 6'h2D}) begin n_fail++; $display("FAIL edge_slot_hit: got %0h expected %0h", {o_rx, o_rs, o_vld, o_pix}, {6'd10, 2'd3, 1'b1, 6'h2D}); end
        pix(1023, 37);
        n_tests++; if ({o_rx, o_ry, o_vld, o_pix} !== {6'd23, 6'd37, 1'b1, 6'h3F}) begin n_fail++; $display("FAIL edge_corner: got %0h expected %0h", {o_rx, o_ry, o_vld, o_pix}, {6'd23, 6'd37, 1'b1, 6'h3F}); end
    endtask

    task automatic test_reset_midstream();
        DrawX = 10'd1010; DrawY = 10'd0;
        repeat (2) @(negedge Clk);
        n_tests++; if (TextValid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_vld: got %0d expected 1", TextValid); end
        #2 Reset = 1'b1;
        #1;
        n_tests++; if ({TextValid, TextPixel, RomX, RomSel} !== 15'h0) begin n_fail++; $display("FAIL async_flush: got %0h expected 0", {TextValid, TextPixel, RomX, RomSel}); end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        pix(1010, 0);
        n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_clears_cfg: got %0d expected 0", o_vld); end
    endtask

`ifdef TEXT_BLINK_EN
    task automatic test_blink();
        do_reset();
        cfg(0, 100, 50, 1, 1'b1, 1'b1);
        cfg(1, 100, 50, 2, 1'b1, 1'b0);
        repeat (29) tick();
        pix(100, 50);
        n_tests++; if ({o_rs, o_pix} !== {2'd1, 6'h21}) begin n_fail++; $display("FAIL blink_tick29_visible: got %0h expected %0h", {o_rs, o_pix}, {2'd1, 6'h21}); end
        tick();
        pix(100, 50);
        n_tests++; if ({o_rs, o_vld, o_pix} !== {2'd2, 1'b1, 6'h22}) begin n_fail++; $display("FAIL blink_tick30_hidden: got %0h expected %0h", {o_rs, o_vld, o_pix}, {2'd2, 1'b1, 6'h22}); end
        repeat (15) tick();
        pix(100, 50);
        n_tests++; if (o_rs !== 2'd2) begin n_fail++; $display("FAIL blink_tick45_hidden: got %0d expected 2", o_rs); end
        do_reset();
        cfg(0, 100, 50, 1, 1'b1, 1'b1);
        tick();
        pix(100, 50);
        n_tests++; if ({o_rs, o_vld} !== {2'd1, 1'b1}) begin n_fail++; $display("FAIL blink_after_reset: got %0h expected %0h", {o_rs, o_vld}, {2'd1, 1'b1}); end
    endtask
`else
    task automatic test_blink();
        cfg(0, 100, 50, 1, 1'b1, 1'b1);
        cfg(1, 100, 50, 2, 1'b1, 1'b0);
        repeat (31) tick();
        pix(100, 50);
        n_tests++; if ({o_rs, o_vld, o_pix} !== {2'd1, 1'b1, 6'h21}) begin n_fail++; $display("FAIL blink_ignored: got %0h expected %0h", {o_rs, o_vld, o_pix}, {2'd1, 1'b1, 6'h21}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_priority();
        test_commit_race();
        test_transparent();
        test_nowrap();
        test_reset_midstream();
        test_blink();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
